// File: rtl/row_addr_gen.sv
// Row-address generator for the edge-detection AHB read master: issues one
// starting address per row transfer, in raster order or as WIN-row sliding windows.
module row_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16,
  parameter int WIN    = 3
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  row_stride,
  input  logic [DIM_W-1:0]  num_rows,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] start_addr_r,
  output logic              addr_valid,
  output logic [DIM_W-1:0]  row_idx,
  output logic              last_row,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DIM_W-1:0] WIN_D  = DIM_W'(WIN);
  localparam logic [DIM_W-1:0] WIN_M1 = DIM_W'(WIN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DIM_W-1:0]    stride_q, stride_d;
  logic [DIM_W-1:0]    rows_q, rows_d;
  logic [DIM_W-1:0]    out_q, out_d;
  logic [DIM_W-1:0]    sub_q, sub_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DIM_W-1:0]    idx_q, idx_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic                sel_mode;
  logic [ADDR_W-1:0]   sel_base;
  logic [DIM_W-1:0]    sel_stride, sel_rows;
  logic [DIM_W-1:0]    row_out, row_sub, row_sum;
  logic [2*DIM_W-1:0]  prod;
  logic [ADDR_W-1:0]   addr_calc;
  logic                last_calc, illegal;

  // One shared address/last calculator: fed by the start command in IDLE
  // (row 0) and by the latched config plus the stepped row counters otherwise.
  always_comb begin
    sel_mode   = (state_q == IDLE) ? mode       : mode_q;
    sel_base   = (state_q == IDLE) ? base_addr  : base_q;
    sel_stride = (state_q == IDLE) ? row_stride : stride_q;
    sel_rows   = (state_q == IDLE) ? num_rows   : rows_q;
    if (state_q == IDLE) begin
      row_out = '0;
      row_sub = '0;
    end else if (mode_q && (sub_q != WIN_M1)) begin
      row_out = out_q;
      row_sub = sub_q + DIM_W'(1);
    end else begin
      row_out = out_q + DIM_W'(1);
      row_sub = '0;
    end
    row_sum   = sel_mode ? (row_out + row_sub) : row_out;
    prod      = {{DIM_W{1'b0}}, sel_stride} * {{DIM_W{1'b0}}, row_sum};
    addr_calc = sel_base + ADDR_W'(prod);
    last_calc = sel_mode ? ((row_out == sel_rows - WIN_D) && (row_sub == WIN_M1))
                         : (row_out == sel_rows - DIM_W'(1));
    illegal   = (num_rows == '0) || (mode && (num_rows < WIN_D));
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    stride_d = stride_q;
    rows_d   = rows_q;
    out_d    = out_q;
    sub_d    = sub_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    last_d   = last_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          base_d   = base_addr;
          stride_d = row_stride;
          rows_d   = num_rows;
          if (illegal) begin
            state_d = FINISH;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            out_d   = row_out;
            sub_d   = row_sub;
            addr_d  = addr_calc;
            idx_d   = row_sum;
            last_d  = last_calc;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (addr_ready) begin
          if (last_q) begin
            state_d = FINISH;
          end else begin
            out_d  = row_out;
            sub_d  = row_sub;
            addr_d = addr_calc;
            idx_d  = row_sum;
            last_d = last_calc;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      base_q   <= '0;
      stride_q <= '0;
      rows_q   <= '0;
      out_q    <= '0;
      sub_q    <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      rows_q   <= rows_d;
      out_q    <= out_d;
      sub_q    <= sub_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign start_addr_r = addr_q;
  assign row_idx      = idx_q;
  assign last_row     = last_q;
  assign addr_valid   = (state_q == ISSUE);
  assign busy         = (state_q == ISSUE);
  assign done         = (state_q == FINISH);
  assign err          = err_q;

endmodule

// File: tb/tb_row_addr_gen.sv
// Directed self-checking bench for row_addr_gen (ADDR_W=32, DIM_W=16, WIN=3).
module tb_row_addr_gen;

  logic        HCLK;
  logic        HRESET;
  logic        start;
  logic        abort;
  logic        mode;
  logic [31:0] base_addr;
  logic [15:0] row_stride;
  logic [15:0] num_rows;
  logic        addr_ready;
  logic [31:0] start_addr_r;
  logic        addr_valid;
  logic [15:0] row_idx;
  logic        last_row;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  row_addr_gen #(.ADDR_W(32), .DIM_W(16), .WIN(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .row_stride(row_stride), .num_rows(num_rows),
    .addr_ready(addr_ready), .start_addr_r(start_addr_r), .addr_valid(addr_valid),
    .row_idx(row_idx), .last_row(last_row), .busy(busy), .done(done), .err(err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [31:0] b, input logic [15:0] s,
                          input logic [15:0] r);
    start = 1'b1; mode = m; base_addr = b; row_stride = s; num_rows = r;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({start_addr_r, row_idx, addr_valid, last_row, busy, done, err} !== 53'd0) begin
      n_err++;
      $display("FAIL reset_outputs got addr=%h idx=%0d v=%b l=%b b=%b d=%b e=%b exp all 0",
               start_addr_r, row_idx, addr_valid, last_row, busy, done, err);
    end
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_raster();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h1000_0000; exp_a[1] = 32'h1000_0280;
    exp_a[2] = 32'h1000_0500; exp_a[3] = 32'h1000_0780;
    addr_ready = 1'b1;
    do_start(1'b0, 32'h1000_0000, 16'd640, 16'd4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({addr_valid, busy, last_row, row_idx, start_addr_r} !==
          {1'b1, 1'b1, (i == 3), 16'(i), exp_a[i]}) begin
        n_err++;
        $display("FAIL raster_%0d got v=%b b=%b l=%b idx=%0d addr=%h exp v=1 b=1 l=%b idx=%0d addr=%h",
                 i, addr_valid, busy, last_row, row_idx, start_addr_r, (i == 3), i, exp_a[i]);
      end
      tick();
    end
    n_cmp++;
    if ({addr_valid, busy, done, err} !== 4'b0010) begin
      n_err++;
      $display("FAIL raster_done got v/b/d/e=%b%b%b%b exp 0010", addr_valid, busy, done, err);
    end
    tick();
    n_cmp++;
    if ({addr_valid, done} !== 2'b00) begin
      n_err++;
      $display("FAIL raster_done_once got v/d=%b%b exp 00", addr_valid, done);
    end
  endtask

  task automatic test_window();
    logic [15:0] exp_r [9];
    logic [31:0] exp_a [9];
    exp_r[0] = 16'd0; exp_r[1] = 16'd1; exp_r[2] = 16'd2;
    exp_r[3] = 16'd1; exp_r[4] = 16'd2; exp_r[5] = 16'd3;
    exp_r[6] = 16'd2; exp_r[7] = 16'd3; exp_r[8] = 16'd4;
    exp_a[0] = 32'h2000; exp_a[1] = 32'h2010; exp_a[2] = 32'h2020;
    exp_a[3] = 32'h2010; exp_a[4] = 32'h2020; exp_a[5] = 32'h2030;
    exp_a[6] = 32'h2020; exp_a[7] = 32'h2030; exp_a[8] = 32'h2040;
    addr_ready = 1'b1;
    do_start(1'b1, 32'h2000, 16'd16, 16'd5);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if ({addr_valid, last_row, row_idx, start_addr_r} !== {1'b1, (i == 8), exp_r[i], exp_a[i]}) begin
        n_err++;
        $display("FAIL window_%0d got v=%b l=%b idx=%0d addr=%h exp v=1 l=%b idx=%0d addr=%h",
                 i, addr_valid, last_row, row_idx, start_addr_r, (i == 8), exp_r[i], exp_a[i]);
      end
      tick();
    end
    n_cmp++;
    if ({addr_valid, done, err} !== 3'b010) begin
      n_err++;
      $display("FAIL window_done got v/d/e=%b%b%b exp 010", addr_valid, done, err);
    end
    tick();
    // rows == WIN: exactly one window of 3 transfers
    do_start(1'b1, 32'h0, 16'd4, 16'd3);
    tick(); tick();
    n_cmp++;
    if ({addr_valid, last_row, row_idx, start_addr_r} !== {1'b1, 1'b1, 16'd2, 32'h8}) begin
      n_err++;
      $display("FAIL window_min got v=%b l=%b idx=%0d addr=%h exp v=1 l=1 idx=2 addr=00000008",
               addr_valid, last_row, row_idx, start_addr_r);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL window_min_done got %b exp 1", done);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int dones;
    addr_ready = 1'b0;
    do_start(1'b0, 32'h3000, 16'h40, 16'd2);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({addr_valid, row_idx, start_addr_r, last_row} !== {1'b1, 16'd0, 32'h3000, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold_%0d got v=%b idx=%0d addr=%h l=%b exp v=1 idx=0 addr=00003000 l=0",
                 i, addr_valid, row_idx, start_addr_r, last_row);
      end
      tick();
    end
    addr_ready = 1'b1;
    tick();
    n_cmp++;
    if ({addr_valid, row_idx, start_addr_r, last_row} !== {1'b1, 16'd1, 32'h3040, 1'b1}) begin
      n_err++;
      $display("FAIL bp_second got v=%b idx=%0d addr=%h l=%b exp v=1 idx=1 addr=00003040 l=1",
               addr_valid, row_idx, start_addr_r, last_row);
    end
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL bp_done_count got %0d exp 1", dones);
    end
  endtask

  task automatic test_illegal();
    addr_ready = 1'b1;
    do_start(1'b0, 32'h100, 16'd8, 16'd0);
    n_cmp++;
    if ({addr_valid, busy, done, err} !== 4'b0011) begin
      n_err++;
      $display("FAIL illegal_rows0 got v/b/d/e=%b%b%b%b exp 0011", addr_valid, busy, done, err);
    end
    tick();
    n_cmp++;
    if ({addr_valid, done, err} !== 3'b000) begin
      n_err++;
      $display("FAIL illegal_rows0_after got v/d/e=%b%b%b exp 000", addr_valid, done, err);
    end
    do_start(1'b1, 32'h100, 16'd8, 16'd2);
    n_cmp++;
    if ({addr_valid, busy, done, err} !== 4'b0011) begin
      n_err++;
      $display("FAIL illegal_win got v/b/d/e=%b%b%b%b exp 0011", addr_valid, busy, done, err);
    end
    tick();
    n_cmp++;
    if ({addr_valid, done, err} !== 3'b000) begin
      n_err++;
      $display("FAIL illegal_win_after got v/d/e=%b%b%b exp 000", addr_valid, done, err);
    end
  endtask

  task automatic test_start_while_busy();
    addr_ready = 1'b0;
    do_start(1'b0, 32'h4000, 16'h10, 16'd2);
    do_start(1'b1, 32'h9999, 16'd7, 16'd9);
    n_cmp++;
    if ({addr_valid, row_idx, start_addr_r} !== {1'b1, 16'd0, 32'h4000}) begin
      n_err++;
      $display("FAIL busy_start_hold got v=%b idx=%0d addr=%h exp v=1 idx=0 addr=00004000",
               addr_valid, row_idx, start_addr_r);
    end
    addr_ready = 1'b1;
    tick();
    n_cmp++;
    if ({addr_valid, last_row, start_addr_r} !== {1'b1, 1'b1, 32'h4010}) begin
      n_err++;
      $display("FAIL busy_start_cfg got v=%b l=%b addr=%h exp v=1 l=1 addr=00004010",
               addr_valid, last_row, start_addr_r);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL busy_start_done got %b exp 1", done);
    end
    // a start landing in FINISH is dropped
    do_start(1'b0, 32'h7000, 16'h10, 16'd2);
    tick();
    n_cmp++;
    if ({addr_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL finish_start_ignored got v/b=%b%b exp 00", addr_valid, busy);
    end
  endtask

  task automatic test_abort();
    int dones;
    addr_ready = 1'b1;
    do_start(1'b0, 32'h5000, 16'h100, 16'd4);
    tick(); tick();
    n_cmp++;
    if ({addr_valid, start_addr_r} !== {1'b1, 32'h5200}) begin
      n_err++;
      $display("FAIL abort_pre got v=%b addr=%h exp v=1 addr=00005200", addr_valid, start_addr_r);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({addr_valid, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_stop got v/b/d=%b%b%b exp 000", addr_valid, busy, done);
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1 || addr_valid === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL abort_quiet got %0d active cycles exp 0", dones);
    end
    do_start(1'b0, 32'h5000, 16'h100, 16'd2);
    n_cmp++;
    if ({addr_valid, row_idx, start_addr_r} !== {1'b1, 16'd0, 32'h5000}) begin
      n_err++;
      $display("FAIL abort_restart got v=%b idx=%0d addr=%h exp v=1 idx=0 addr=00005000",
               addr_valid, row_idx, start_addr_r);
    end
    tick(); tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL abort_restart_done got %b exp 1", done);
    end
    tick();
  endtask

  task automatic test_hreset_mid();
    addr_ready = 1'b1;
    do_start(1'b0, 32'h6000, 16'h20, 16'd4);
    tick();
    HRESET = 1'b1;
    start = 1'b1;
    tick();
    n_cmp++;
    if ({start_addr_r, row_idx, addr_valid, last_row, busy, done, err} !== 53'd0) begin
      n_err++;
      $display("FAIL hreset_mid got addr=%h idx=%0d v=%b l=%b b=%b d=%b e=%b exp all 0",
               start_addr_r, row_idx, addr_valid, last_row, busy, done, err);
    end
    HRESET = 1'b0;
    start = 1'b0;
    tick();
    n_cmp++;
    if ({addr_valid, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL hreset_idle got v/b/d=%b%b%b exp 000", addr_valid, busy, done);
    end
  endtask

  task automatic test_wrap();
    addr_ready = 1'b1;
    do_start(1'b0, 32'hFFFF_FF00, 16'h100, 16'd2);
    n_cmp++;
    if (start_addr_r !== 32'hFFFF_FF00) begin
      n_err++;
      $display("FAIL wrap_first got %h exp ffffff00", start_addr_r);
    end
    tick();
    n_cmp++;
    if ({addr_valid, last_row, start_addr_r} !== {1'b1, 1'b1, 32'h0000_0000}) begin
      n_err++;
      $display("FAIL wrap_second got v=%b l=%b addr=%h exp v=1 l=1 addr=00000000",
               addr_valid, last_row, start_addr_r);
    end
    tick();
    n_cmp++;
    if ({done, err} !== 2'b10) begin
      n_err++;
      $display("FAIL wrap_done got d/e=%b%b exp 10", done, err);
    end
    tick();
  endtask

  initial begin
    HRESET = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    base_addr = '0; row_stride = '0; num_rows = '0; addr_ready = 1'b0;
    test_reset();
    test_raster();
    test_window();
    test_backpressure();
    test_illegal();
    test_start_while_busy();
    test_abort();
    test_hreset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/row_addr_gen.md
Name: row_addr_gen

Overview:
- Parametrised row-address generator for the AHB read master of the edge-detection datapath.
- Replaces the fixed three-row read-address counter.
- A start command latches base address, row stride, image height and mode. The block then issues one starting address per row transfer over a valid/ready handshake.
- Supports plain raster mode and sliding-window mode. Window mode emits WIN consecutive rows per output row, as needed for the WIN x WIN convolution kernel.

Parameters:
- ADDR_W, 32, address width.
- DIM_W, 16, width of stride and height fields.
- WIN, 3, window height in rows for window mode (>=1).

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; honoured only in IDLE.
- abort  in  1  cancel the current sequence.
- mode  in  1  0 = raster, 1 = window; sampled with start.
- base_addr  in  ADDR_W  image base address; sampled with start.
- row_stride  in  DIM_W  bytes per row (image length); sampled with start.
- num_rows  in  DIM_W  image height in rows; sampled with start.
- addr_ready  in  1  AHB master accepts the current address.
- start_addr_r  out  ADDR_W  starting address of the current row transfer.
- addr_valid  out  1  start_addr_r is valid.
- row_idx  out  DIM_W  absolute row number of start_addr_r.
- last_row  out  1  current address is the final one of the sequence.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  one-cycle pulse: illegal command.

Behaviour:
- Reset (HRESET high at a HCLK edge): state IDLE. All outputs 0. Internal counters and latched config cleared. Reset overrides start and abort in the same cycle, including mid-sequence.
- States: IDLE, ISSUE, FINISH.
- IDLE:
  - On start, latch mode, base_addr, row_stride and num_rows.
  - If num_rows==0, or (mode==1 and num_rows<WIN), go to FINISH with err=1. No address is ever issued.
  - Otherwise go to ISSUE with out_row=0 and sub_row=0.
- ISSUE:
  - addr_valid=1 and busy=1. addr_valid first rises the cycle after start (latency 1).
  - start_addr_r = base + row_stride*row_idx, truncated modulo 2^ADDR_W. The product is zero-extended to ADDR_W.
  - row_idx = out_row + sub_row in window mode, out_row in raster mode.
  - start_addr_r, row_idx and last_row are registered and held stable while addr_valid && !addr_ready.
- Advance happens only on addr_valid && addr_ready:
  - Raster: out_row increments. last_row is high when out_row==num_rows-1.
  - Window: sub_row increments. When sub_row==WIN-1 it wraps to 0 and out_row increments. last_row is high when out_row==num_rows-WIN and sub_row==WIN-1.
  - Total transfers: raster = num_rows; window = (num_rows-WIN+1)*WIN.
- Handshake on the last address → FINISH. addr_valid drops the next cycle. No idle gap between consecutive addresses otherwise: one address per cycle when addr_ready is held high.
- FINISH: done=1 for exactly one cycle (err also 1 if illegal), busy=0, then IDLE. start arriving during FINISH is ignored.
- start while busy: ignored, with no effect on latched config.
- abort in ISSUE: next cycle addr_valid=0, busy=0, state IDLE. No done pulse. A handshake in the same cycle as abort still counts on the bus side, but the sequence ends. abort in IDLE or FINISH has no effect.
- Wrap-around: address arithmetic wraps silently at 2^ADDR_W. No error is flagged.

Test Plan:
- Raster: base=0x1000_0000, stride=640, rows=4, mode=0, ready held 1 → addresses 0x1000_0000, 0x1000_0280, 0x1000_0500, 0x1000_0780 on 4 consecutive cycles; last_row on the 4th; done 1 cycle later.
- Window, WIN=3: base=0x2000, stride=16, rows=5 → 9 addresses in row order 0,1,2,1,2,3,2,3,4 (0x2000, 0x2010, 0x2020, 0x2010, …, 0x2040); last_row only on the 9th.
- Backpressure: raster, rows=2, addr_ready low for 3 cycles on the first address → start_addr_r/row_idx stable throughout; exactly 2 handshakes; done once.
- Illegal commands: rows=0 in mode 0, or rows=2 in mode 1 → addr_valid never rises; err and done pulse together the cycle after start; start during busy is ignored.
- Abort and reset: abort after 2 of 4 raster handshakes → addr_valid=0 and busy=0 next cycle, no done; new start then runs cleanly from row 0. HRESET mid-ISSUE → all outputs 0 on the next edge.
- Wrap: base=0xFFFF_FF00, stride=0x100, rows=2 → 0xFFFF_FF00, then 0x0000_0000.
